// File: rtl/sys_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// sys_cmd_ctrl
//   Command-frame controller between the synchronized UART RX byte stream and
//   the shared register file, ALU and TX FIFO. Decodes one command frame at a
//   time, issues single-cycle strobes to the register file / ALU and pushes
//   the response bytes into the TX FIFO.
//
//   Commands (first byte of a frame):
//     0xAA addr data      register write, no response
//     0xBB addr           register read, response = 1 byte of read data
//     0xCC opA opB fun    write opA->RF[0], opB->RF[1], run ALU, 2-byte response
//     0xDD fun            run ALU on current RF[0]/RF[1], 2-byte response
//
// Ports
//   REF_CLK, RST_N          clock (rising edge), asynchronous active-low reset
//   RX_P_DATA, RX_D_VLD     received byte and its one-cycle valid pulse
//   RF_ADDR, RF_WR_EN, RF_RD_EN, RF_WR_DATA   register file request side
//   RF_RD_DATA, RF_RD_VLD   register file read response
//   ALU_EN, ALU_FUN         ALU start strobe and function code
//   CLK_GATE_EN             ALU clock-gate enable, high while an op is pending
//   ALU_OUT, ALU_OUT_VLD    ALU result and its valid pulse
//   FIFO_WR_DATA, FIFO_WR_INC, FIFO_FULL      TX FIFO push interface
//   BUSY                    high whenever a frame or response is in progress
//
//   Every output is a register; strobes appear the cycle after the decision.
// -----------------------------------------------------------------------------
module sys_cmd_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int ALU_WIDTH      = 16,
    parameter int ADDR_WIDTH     = 4,
    parameter int FUN_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 16384
) (
    input  logic                  REF_CLK,
    input  logic                  RST_N,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    output logic [ADDR_WIDTH-1:0] RF_ADDR,
    output logic                  RF_WR_EN,
    output logic                  RF_RD_EN,
    output logic [DATA_WIDTH-1:0] RF_WR_DATA,
    input  logic [DATA_WIDTH-1:0] RF_RD_DATA,
    input  logic                  RF_RD_VLD,
    output logic                  ALU_EN,
    output logic [FUN_WIDTH-1:0]  ALU_FUN,
    output logic                  CLK_GATE_EN,
    input  logic [ALU_WIDTH-1:0]  ALU_OUT,
    input  logic                  ALU_OUT_VLD,
    output logic [DATA_WIDTH-1:0] FIFO_WR_DATA,
    output logic                  FIFO_WR_INC,
    input  logic                  FIFO_FULL,
    output logic                  BUSY
);

    localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_NO = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_OP_A,
        ST_OP_B,
        ST_FUN,
        ST_ALU_WAIT,
        ST_TX_RD,
        ST_TX_LO,
        ST_TX_HI
    } state_t;

    state_t                  state_reg, state_next;
    logic [CNT_WIDTH-1:0]    cnt_reg, cnt_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [DATA_WIDTH-1:0]   rd_data_reg, rd_data_next;
    logic [ALU_WIDTH-1:0]    alu_res_reg, alu_res_next;

    logic [ADDR_WIDTH-1:0]   rf_addr_reg, rf_addr_next;
    logic                    rf_wr_en_reg, rf_wr_en_next;
    logic                    rf_rd_en_reg, rf_rd_en_next;
    logic [DATA_WIDTH-1:0]   rf_wr_data_reg, rf_wr_data_next;
    logic                    alu_en_reg, alu_en_next;
    logic [FUN_WIDTH-1:0]    alu_fun_reg, alu_fun_next;
    logic                    clk_gate_en_reg, clk_gate_en_next;
    logic [DATA_WIDTH-1:0]   fifo_wr_data_reg, fifo_wr_data_next;
    logic                    fifo_wr_inc_reg, fifo_wr_inc_next;
    logic                    busy_reg, busy_next;

    logic                    timeout_hit;

    // States that wait for the next RX byte; only these run the timeout.
    function automatic logic is_collecting(input state_t st);
        logic res;
        res = 1'b0;
        case (st)
            ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR,
            ST_OP_A, ST_OP_B, ST_FUN: res = 1'b1;
            default:                  res = 1'b0;
        endcase
        return res;
    endfunction

    always_comb begin
        state_next        = state_reg;
        addr_next         = addr_reg;
        rd_data_next      = rd_data_reg;
        alu_res_next      = alu_res_reg;
        rf_addr_next      = rf_addr_reg;
        rf_wr_data_next   = rf_wr_data_reg;
        alu_fun_next      = alu_fun_reg;
        fifo_wr_data_next = fifo_wr_data_reg;
        rf_wr_en_next     = 1'b0;
        rf_rd_en_next     = 1'b0;
        alu_en_next       = 1'b0;
        fifo_wr_inc_next  = 1'b0;
        timeout_hit       = (cnt_reg == CNT_LAST);

        case (state_reg)
            ST_IDLE: begin
                if (RX_D_VLD) begin
                    case (RX_P_DATA)
                        CMD_WR:     state_next = ST_WR_ADDR;
                        CMD_RD:     state_next = ST_RD_ADDR;
                        CMD_ALU_OP: state_next = ST_OP_A;
                        CMD_ALU_NO: state_next = ST_FUN;
                        default:    ;
                    endcase
                end
            end
            ST_WR_ADDR: begin
                if (RX_D_VLD) begin
                    addr_next  = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_next = ST_WR_DATA;
                end else if (timeout_hit) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WR_DATA: begin
                if (RX_D_VLD) begin
                    rf_wr_en_next   = 1'b1;
                    rf_addr_next    = addr_reg;
                    rf_wr_data_next = RX_P_DATA;
                    state_next      = ST_IDLE;
                end else if (timeout_hit) begin
                    state_next = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                if (RX_D_VLD) begin
                    rf_rd_en_next = 1'b1;
                    rf_addr_next  = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_next    = ST_RD_WAIT;
                end else if (timeout_hit) begin
                    state_next = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                if (RF_RD_VLD) begin
                    rd_data_next = RF_RD_DATA;
                    state_next   = ST_TX_RD;
                end
            end
            // Operands go through the register file so the ALU always reads
            // its inputs from RF[0] and RF[1].
            ST_OP_A: begin
                if (RX_D_VLD) begin
                    rf_wr_en_next   = 1'b1;
                    rf_addr_next    = ADDR_WIDTH'(0);
                    rf_wr_data_next = RX_P_DATA;
                    state_next      = ST_OP_B;
                end else if (timeout_hit) begin
                    state_next = ST_IDLE;
                end
            end
            ST_OP_B: begin
                if (RX_D_VLD) begin
                    rf_wr_en_next   = 1'b1;
                    rf_addr_next    = ADDR_WIDTH'(1);
                    rf_wr_data_next = RX_P_DATA;
                    state_next      = ST_FUN;
                end else if (timeout_hit) begin
                    state_next = ST_IDLE;
                end
            end
            ST_FUN: begin
                if (RX_D_VLD) begin
                    alu_en_next  = 1'b1;
                    alu_fun_next = RX_P_DATA[FUN_WIDTH-1:0];
                    state_next   = ST_ALU_WAIT;
                end else if (timeout_hit) begin
                    state_next = ST_IDLE;
                end
            end
            ST_ALU_WAIT: begin
                if (ALU_OUT_VLD) begin
                    alu_res_next = ALU_OUT;
                    state_next   = ST_TX_LO;
                end
            end
            // Push decisions are taken only when the FIFO reports room, so a
            // full FIFO simply parks the response in the current state.
            ST_TX_RD: begin
                if (!FIFO_FULL) begin
                    fifo_wr_inc_next  = 1'b1;
                    fifo_wr_data_next = rd_data_reg;
                    state_next        = ST_IDLE;
                end
            end
            ST_TX_LO: begin
                if (!FIFO_FULL) begin
                    fifo_wr_inc_next  = 1'b1;
                    fifo_wr_data_next = alu_res_reg[DATA_WIDTH-1:0];
                    state_next        = ST_TX_HI;
                end
            end
            ST_TX_HI: begin
                if (!FIFO_FULL) begin
                    fifo_wr_inc_next  = 1'b1;
                    fifo_wr_data_next = alu_res_reg[ALU_WIDTH-1 -: DATA_WIDTH];
                    state_next        = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Counter restarts on any received byte and on entering a collecting
        // state; it only advances while parked in the same collecting state.
        if (is_collecting(state_next) && !RX_D_VLD && (state_next == state_reg)) begin
            cnt_next = cnt_reg + 1'b1;
        end else begin
            cnt_next = '0;
        end

        busy_next        = (state_next != ST_IDLE);
        clk_gate_en_next = (state_next == ST_FUN) || (state_next == ST_ALU_WAIT);
    end

    always_ff @(posedge REF_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg        <= ST_IDLE;
            cnt_reg          <= '0;
            addr_reg         <= '0;
            rd_data_reg      <= '0;
            alu_res_reg      <= '0;
            rf_addr_reg      <= '0;
            rf_wr_en_reg     <= 1'b0;
            rf_rd_en_reg     <= 1'b0;
            rf_wr_data_reg   <= '0;
            alu_en_reg       <= 1'b0;
            alu_fun_reg      <= '0;
            clk_gate_en_reg  <= 1'b0;
            fifo_wr_data_reg <= '0;
            fifo_wr_inc_reg  <= 1'b0;
            busy_reg         <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            addr_reg         <= addr_next;
            rd_data_reg      <= rd_data_next;
            alu_res_reg      <= alu_res_next;
            rf_addr_reg      <= rf_addr_next;
            rf_wr_en_reg     <= rf_wr_en_next;
            rf_rd_en_reg     <= rf_rd_en_next;
            rf_wr_data_reg   <= rf_wr_data_next;
            alu_en_reg       <= alu_en_next;
            alu_fun_reg      <= alu_fun_next;
            clk_gate_en_reg  <= clk_gate_en_next;
            fifo_wr_data_reg <= fifo_wr_data_next;
            fifo_wr_inc_reg  <= fifo_wr_inc_next;
            busy_reg         <= busy_next;
        end
    end

    assign RF_ADDR      = rf_addr_reg;
    assign RF_WR_EN     = rf_wr_en_reg;
    assign RF_RD_EN     = rf_rd_en_reg;
    assign RF_WR_DATA   = rf_wr_data_reg;
    assign ALU_EN       = alu_en_reg;
    assign ALU_FUN      = alu_fun_reg;
    assign CLK_GATE_EN  = clk_gate_en_reg;
    assign FIFO_WR_DATA = fifo_wr_data_reg;
    assign FIFO_WR_INC  = fifo_wr_inc_reg;
    assign BUSY         = busy_reg;

endmodule
